// File: rtl/storage_acc_pkg.sv
// Shared types and constants for the secure storage request front-end.
// Imported by the permission table and the top-level controller.
package storage_acc_pkg;

    localparam int REGION_BITS_DEF = 2;

    localparam int PERM_RD_BIT = 0;
    localparam int PERM_WR_BIT = 1;

    localparam logic [1:0] PERM_DENY = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Selects the permission bit that matches the request direction.
    function automatic logic perm_allows(input logic [1:0] perm, input logic is_write);
        logic allow;
        if (is_write) begin
            allow = perm[PERM_WR_BIT];
        end else begin
            allow = perm[PERM_RD_BIT];
        end
        return allow;
    endfunction

endpackage

// File: rtl/region_perm_table.sv
// Per-region permission and lock registers with a combinational lookup port.
// Locked regions reject updates and report it with a one-cycle cfg_err pulse.
module region_perm_table
    import storage_acc_pkg::*;
#(
    parameter int REGION_BITS = REGION_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_valid,
    input  logic [REGION_BITS-1:0] cfg_region,
    input  logic [1:0]             cfg_perm,
    input  logic                   cfg_lock,
    output logic                   cfg_err,
    input  logic [REGION_BITS-1:0] lk_region,
    output logic [1:0]             lk_perm
);

    localparam int NREG = 1 << REGION_BITS;

    logic [NREG-1:0][1:0] perm_r;
    logic [NREG-1:0]      lock_r;
    logic                 cfg_err_r;

    // Permission/lock update; a lock bit can only be cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perm_r    <= {NREG{PERM_DENY}};
            lock_r    <= {NREG{1'b0}};
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= 1'b0;
            if (cfg_valid) begin
                if (lock_r[cfg_region]) begin
                    cfg_err_r <= 1'b1;
                end else begin
                    perm_r[cfg_region] <= cfg_perm;
                    if (cfg_lock) begin
                        lock_r[cfg_region] <= 1'b1;
                    end
                end
            end
        end
    end

    // Lookup sees the pre-update entry, so a same-edge update cannot widen a check.
    assign lk_perm = perm_r[lk_region];
    assign cfg_err = cfg_err_r;

endmodule

// File: rtl/storage_access_ctrl.sv
// Request front-end for the secure storage array: permission check, single
// outstanding request sequencing, storage pin drive and violation counting.
module storage_access_ctrl
    import storage_acc_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int REGION_BITS = REGION_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   rsp_err,
    input  logic                   cfg_valid,
    input  logic [REGION_BITS-1:0] cfg_region,
    input  logic [1:0]             cfg_perm,
    input  logic                   cfg_lock,
    output logic                   cfg_err,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    output logic                   mem_we,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic [7:0]             viol_count
);

    state_e                 state_r;
    state_e                 state_n;
    logic                   wr_r;
    logic                   req_ready_r;
    logic                   rsp_valid_r;
    logic [DATA_W-1:0]      rsp_rdata_r;
    logic                   rsp_err_r;
    logic [ADDR_W-1:0]      mem_addr_r;
    logic [DATA_W-1:0]      mem_wdata_r;
    logic                   mem_we_r;
    logic [7:0]             viol_r;

    logic [REGION_BITS-1:0] region_s;
    logic [1:0]             lk_perm_s;
    logic                   accept_s;
    logic                   allow_s;
    logic                   issue_s;
    logic                   deny_s;
    logic                   mem_we_n;

    assign region_s = req_addr[ADDR_W-1 -: REGION_BITS];

    region_perm_table #(
        .REGION_BITS (REGION_BITS)
    ) u_perm (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_region (cfg_region),
        .cfg_perm   (cfg_perm),
        .cfg_lock   (cfg_lock),
        .cfg_err    (cfg_err),
        .lk_region  (region_s),
        .lk_perm    (lk_perm_s)
    );

    // Acceptance decode and next-state logic.
    always_comb begin
        state_n  = state_r;
        accept_s = 1'b0;
        allow_s  = perm_allows(lk_perm_s, req_write);
        issue_s  = 1'b0;
        deny_s   = 1'b0;
        mem_we_n = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid && req_ready_r) begin
                    accept_s = 1'b1;
                    if (allow_s) begin
                        issue_s  = 1'b1;
                        mem_we_n = req_write;
                        state_n  = ST_ISSUE;
                    end else begin
                        deny_s  = 1'b1;
                        state_n = ST_RESP;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (wr_r) begin
                    state_n = ST_RESP;
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                state_n = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_RESP;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State register and handshake flags, all derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            req_ready_r <= (state_n == ST_IDLE);
            rsp_valid_r <= (state_n == ST_RESP);
        end
    end

    // Storage pins: address/data latched on a permitted accept, we for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_r        <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_we_r    <= 1'b0;
        end else begin
            mem_we_r <= mem_we_n;
            if (accept_s) begin
                wr_r <= req_write;
            end
            if (issue_s) begin
                mem_addr_r <= req_addr;
                if (req_write) begin
                    mem_wdata_r <= req_wdata;
                end
            end
        end
    end

    // Response payload and saturating violation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_r <= {DATA_W{1'b0}};
            rsp_err_r   <= 1'b0;
            viol_r      <= 8'd0;
        end else begin
            if (accept_s) begin
                rsp_rdata_r <= {DATA_W{1'b0}};
                rsp_err_r   <= deny_s;
            end else if (state_r == ST_WAIT) begin
                rsp_rdata_r <= mem_rdata;
            end
            if (deny_s && (viol_r != 8'hFF)) begin
                viol_r <= viol_r + 8'd1;
            end
        end
    end

    assign req_ready  = req_ready_r;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_err    = rsp_err_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign mem_we     = mem_we_r;
    assign viol_count = viol_r;

endmodule

// File: tb/tb_storage_access_ctrl.sv
// Directed self-checking bench for storage_access_ctrl with a 256x32
// one-cycle-latency storage model.
module tb_storage_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        cfg_valid = 1'b0;
    logic [1:0]  cfg_region = 2'd0;
    logic [1:0]  cfg_perm = 2'b00;
    logic        cfg_lock = 1'b0;
    logic        cfg_err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [7:0]  viol_count;

    logic [31:0] mem_model [256];
    logic        mem_clr = 1'b1;
    int          we_cnt = 0;
    int          total = 0;
    int          bad = 0;
    int          exp_viol = 0;

    storage_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .cfg_valid(cfg_valid), .cfg_region(cfg_region), .cfg_perm(cfg_perm), .cfg_lock(cfg_lock),
        .cfg_err(cfg_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .viol_count(viol_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem_model[i] <= 32'h0;
            mem_rdata <= 32'h0;
        end else begin
            mem_rdata <= mem_model[mem_addr];
            if (mem_we) mem_model[mem_addr] <= mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (mem_we === 1'b1) we_cnt <= we_cnt + 1;
    end

    // Called #1 after a posedge; returns read data, error, latency from accept edge, we cycles.
    task automatic do_req(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat, output int wes);
        int we0;
        int guard;
        we0 = we_cnt;
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        total++;
        if (guard >= 20) begin
            bad++;
            $display("FAIL accept_timeout addr=%h got req_ready=%b want 1", addr, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        wes = we_cnt - we0;
    endtask

    task automatic do_cfg(input logic [1:0] region, input logic [1:0] perm, input logic lock,
                          output logic err_pulse);
        cfg_valid = 1'b1; cfg_region = region; cfg_perm = perm; cfg_lock = lock;
        @(posedge clk); #1;
        cfg_valid = 1'b0; cfg_lock = 1'b0;
        err_pulse = cfg_err;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; mem_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%b want=0", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we got=%b want=0", mem_we); end
        total++; if (mem_addr !== 8'h00 || mem_wdata !== 32'h0) begin bad++; $display("FAIL rst_mem_bus got=%h/%h want=0/0", mem_addr, mem_wdata); end
        total++; if (rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp got=%h/%b want=0/0", rsp_rdata, rsp_err); end
        total++; if (viol_count !== 8'd0 || cfg_err !== 1'b0) begin bad++; $display("FAIL rst_viol_cfg got=%0d/%b want=0/0", viol_count, cfg_err); end
        rst_n = 1'b1; mem_clr = 1'b0;
        @(posedge clk); #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", req_ready); end
    endtask

    task automatic test_deny_default();
        logic [31:0] rd; logic er; int lat; int wes;
        do_req(1'b0, 8'h10, 32'h0, rd, er, lat, wes);
        exp_viol++;
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL deny_rsp got err=%b rdata=%h want 1/0", er, rd); end
        total++; if (lat != 1) begin bad++; $display("FAIL deny_latency got=%0d want=1", lat); end
        total++; if (wes != 0) begin bad++; $display("FAIL deny_mem_we got=%0d cycles want=0", wes); end
        total++; if (viol_count !== 8'(exp_viol)) begin bad++; $display("FAIL deny_viol got=%0d want=%0d", viol_count, exp_viol); end
    endtask

    task automatic test_read_write();
        logic [31:0] rd; logic er; int lat; int wes; logic ce;
        do_cfg(2'd0, 2'b11, 1'b0, ce);
        total++; if (ce !== 1'b0) begin bad++; $display("FAIL cfg0_err got=%b want=0", ce); end
        do_req(1'b1, 8'h05, 32'hDEADBEEF, rd, er, lat, wes);
        total++; if (er !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL wr_rsp got err=%b rdata=%h want 0/0", er, rd); end
        total++; if (lat != 2) begin bad++; $display("FAIL wr_latency got=%0d want=2", lat); end
        total++; if (wes != 1) begin bad++; $display("FAIL wr_we_cycles got=%0d want=1", wes); end
        total++; if (mem_model[5] !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_storage got=%h want=deadbeef", mem_model[5]); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_rsp got=%b want=1", req_ready); end
        do_req(1'b0, 8'h05, 32'h0, rd, er, lat, wes);
        total++; if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rsp got err=%b rdata=%h want 0/deadbeef", er, rd); end
        total++; if (lat != 3) begin bad++; $display("FAIL rd_latency got=%0d want=3", lat); end
        total++; if (wes != 0 || mem_addr !== 8'h05) begin bad++; $display("FAIL rd_pins got we=%0d addr=%h want 0/05", wes, mem_addr); end
    endtask

    task automatic test_lock();
        logic [31:0] rd; logic er; int lat; int wes; logic ce;
        do_cfg(2'd3, 2'b01, 1'b1, ce);
        total++; if (ce !== 1'b0) begin bad++; $display("FAIL cfg3_lock_err got=%b want=0", ce); end
        do_req(1'b1, 8'hC0, 32'h11112222, rd, er, lat, wes);
        exp_viol++;
        total++; if (er !== 1'b1 || wes != 0) begin bad++; $display("FAIL lock_wr_deny got err=%b we=%0d want 1/0", er, wes); end
        do_req(1'b0, 8'hC0, 32'h0, rd, er, lat, wes);
        total++; if (er !== 1'b0 || rd !== 32'h0 || lat != 3) begin bad++; $display("FAIL lock_rd_ok got err=%b rdata=%h lat=%0d want 0/0/3", er, rd, lat); end
        do_cfg(2'd3, 2'b11, 1'b0, ce);
        total++; if (ce !== 1'b1) begin bad++; $display("FAIL locked_cfg_err got=%b want=1", ce); end
        @(posedge clk); #1;
        total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_pulse got=%b want=0", cfg_err); end
        do_req(1'b1, 8'hC0, 32'h33334444, rd, er, lat, wes);
        exp_viol++;
        total++; if (er !== 1'b1 || wes != 0) begin bad++; $display("FAIL locked_wr_deny got err=%b we=%0d want 1/0", er, wes); end
        total++; if (viol_count !== 8'(exp_viol)) begin bad++; $display("FAIL lock_viol got=%0d want=%0d", viol_count, exp_viol); end
    endtask

    task automatic test_hold_response();
        int guard;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h05;
        @(posedge clk); #1;
        req_addr = 8'h06;
        guard = 0;
        while (rsp_valid !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d got valid=%b rdata=%h ready=%b want 1/deadbeef/0", i, rsp_valid, rsp_rdata, req_ready);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0 || mem_addr !== 8'h05) begin bad++; $display("FAIL hold_no_second got valid=%b addr=%h want 0/05", rsp_valid, mem_addr); end
    endtask

    task automatic test_same_edge_cfg();
        logic [31:0] rd; logic er; int lat; int wes;
        cfg_valid = 1'b1; cfg_region = 2'd1; cfg_perm = 2'b11; cfg_lock = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40;
        @(posedge clk); #1;
        cfg_valid = 1'b0; req_valid = 1'b0;
        exp_viol++;
        total++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1) begin bad++; $display("FAIL same_edge_pre_entry got valid=%b err=%b want 1/1", rsp_valid, rsp_err); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        do_req(1'b0, 8'h40, 32'h0, rd, er, lat, wes);
        total++; if (er !== 1'b0 || lat != 3) begin bad++; $display("FAIL same_edge_after got err=%b lat=%0d want 0/3", er, lat); end
    endtask

    task automatic test_saturate();
        logic [31:0] rd; logic er; int lat; int wes;
        for (int i = 0; i < 300; i++) begin
            do_req(1'b1, 8'h80, 32'(i), rd, er, lat, wes);
            if (exp_viol < 255) exp_viol++;
            total++;
            if (er !== 1'b1 || viol_count !== 8'(exp_viol)) begin
                bad++;
                $display("FAIL sat_iter%0d got err=%b viol=%0d want 1/%0d", i, er, viol_count, exp_viol);
            end
        end
        total++; if (viol_count !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d want=255", viol_count); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd; logic er; int lat; int wes;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h07; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL issue_we got=%b want=1", mem_we); end
        rst_n = 1'b0;
        #1;
        total++; if (mem_we !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL async_rst got we=%b ready=%b valid=%b want 0/0/0", mem_we, req_ready, rsp_valid); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_no_rsp cycle%0d got=%b want=0", i, rsp_valid); end
        end
        total++; if (mem_model[7] !== 32'h0 || viol_count !== 8'd0) begin bad++; $display("FAIL rst_discard got mem=%h viol=%0d want 0/0", mem_model[7], viol_count); end
        for (int r = 0; r < 4; r++) begin
            do_req(1'b0, 8'(r * 64 + 3), 32'h0, rd, er, lat, wes);
            total++; if (er !== 1'b1 || lat != 1) begin bad++; $display("FAIL rst_perm_rd r%0d got err=%b lat=%0d want 1/1", r, er, lat); end
        end
        do_req(1'b1, 8'hC1, 32'h5, rd, er, lat, wes);
        total++; if (er !== 1'b1 || viol_count !== 8'd5) begin bad++; $display("FAIL rst_perm_wr got err=%b viol=%0d want 1/5", er, viol_count); end
    endtask

    initial begin
        test_reset();
        test_deny_default();
        test_read_write();
        test_lock();
        test_hold_response();
        test_same_edge_cfg();
        test_saturate();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/storage_access_ctrl.md
# storage_access_ctrl

Request front-end for the 256 x 32 secure storage array. It accepts read/write requests on a valid/ready handshake and checks each against a per-region permission table. The permission table resets to deny-all and is lockable per region. Permitted requests drive the storage's address, write-data and write-enable pins and capture its one-cycle-latency read data; denied requests are answered with an error and never reach the array.

## Interface
- ADDR_W, 8, storage address width
- DATA_W, 32, storage data width
- REGION_BITS, 2, number of top address bits that select the region (4 regions of 64 words)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data; 0 for writes and denied requests
- rsp_err  out  1  1 = permission denied
- cfg_valid  in  1  permission update strobe
- cfg_region  in  REGION_BITS  region to update
- cfg_perm  in  2  bit1 = write allowed, bit0 = read allowed
- cfg_lock  in  1  lock the region after this update
- cfg_err  out  1  one-cycle pulse: update rejected because the region is locked
- mem_addr  out  ADDR_W  to storage address
- mem_wdata  out  DATA_W  to storage write data
- mem_we  out  1  to storage write enable
- mem_rdata  in  DATA_W  from storage; valid one cycle after mem_addr is presented
- viol_count  out  8  count of denied requests, saturating

## Operation
- Reset values: every permission entry = 2'b00 (deny); every lock bit = 0; state IDLE; req_ready = 0 during reset; rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, cfg_err = 0, viol_count = 0.
- Region select: region = req_addr[ADDR_W-1 -: REGION_BITS].
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready = 1. On req_valid, latch write, addr and wdata, then check the permission entry of the region.
  - Denied: go to RESP with rsp_err = 1 and rsp_rdata = 0. viol_count increments, saturating at 255. mem_we stays 0.
  - Permitted: go to ISSUE.
- ISSUE: mem_addr = latched address.
  - Write: mem_we = 1 and mem_wdata = latched data for exactly this cycle, then go to RESP with rdata = 0.
  - Read: mem_we = 0, then go to WAIT.
- WAIT: capture mem_rdata into rsp_rdata at the end of the cycle, then go to RESP.
- RESP: rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_ready, go to IDLE. req_ready = 0 in every state except IDLE.
- Permission update: cfg_valid applies cfg_perm to the region at the clock edge if that region is unlocked. If cfg_lock = 1, the lock bit is also set; it stays set until reset.
- Update to a locked region: the table is unchanged and cfg_err pulses for one cycle.
- Simultaneous cfg update and request acceptance, same region: the check uses the pre-update entry.
- mem_addr holds its last value outside ISSUE; mem_we is 0 in every state except ISSUE.

## Timing
- A request is accepted at edge E0.
- Denied request: rsp_valid at E0+1.
- Write: mem_we high in cycle E0..E1; rsp_valid at E0+2.
- Read: mem_addr presented in ISSUE; storage data valid in WAIT; rsp_valid at E0+3.
- Throughput: one outstanding request. After rsp_ready is seen at edge R, req_ready is high from R+1.
- Reset asserted mid-operation: the FSM returns to IDLE immediately; the pending request is discarded with no response; mem_we drops to 0 asynchronously.

## Structure
- Package storage_acc_pkg holds:
  - the state enum;
  - PERM_RD_BIT = 0 and PERM_WR_BIT = 1;
  - PERM_DENY = 2'b00;
  - the REGION_BITS default.
- Sub-module region_perm_table: holds the 2^REGION_BITS perm and lock registers, the cfg write and lock logic, cfg_err, and a combinational lookup port (region in, perm out). The top-level module holds the FSM, the datapath latches and viol_count.

## Test plan
- Read at addr 0x10 straight after reset, no config → rsp_err = 1, rsp_rdata = 0, mem_we never high, viol_count = 1.
- cfg region 0, perm 2'b11; write 0xDEADBEEF to 0x05, then read 0x05 → write response err = 0 at E0+2; read returns 0xDEADBEEF at E0+3.
- cfg region 3, perm 2'b01 with lock; write to 0xC0 → err = 1. Then cfg region 3, perm 2'b11 → cfg_err pulses and the next write to 0xC0 still returns err = 1.
- Hold rsp_ready = 0 for 5 cycles during a read response → rsp_valid and rsp_rdata are stable; req_ready = 0; a second req_valid is not accepted.
- Issue 300 denied requests → viol_count saturates at 255.
- Assert rst_n low during ISSUE of a permitted write → mem_we drops at once; after release all permissions are 2'b00 and no response is produced.
